// File: rtl/histo_accum.sv
// Per-frame pixel histogram: bins fv&&lv pixels into a count RAM, then streams and clears every bin at end of frame.
// Optional macro HISTO_SATURATE_EN: bins stick at 2^CNT_W-1 instead of wrapping.
module histo_accum #(
  parameter int PIX_W    = 10,
  parameter int BIN_BITS = 8,
  parameter int CNT_W    = 24
) (
  input  logic                clk_pixel_i,
  input  logic                reset_n_i,
  input  logic                fv_i,
  input  logic                lv_i,
  input  logic [PIX_W-1:0]    pd_i,
  input  logic                hist_ready_i,
  output logic                hist_valid_o,
  output logic [BIN_BITS-1:0] hist_bin_o,
  output logic [CNT_W-1:0]    hist_count_o,
  output logic                hist_last_o,
  output logic                frame_done_o,
  output logic                frame_drop_o,
  output logic                busy_o
);
  localparam int NBINS = 1 << BIN_BITS;
  localparam logic [BIN_BITS-1:0] LAST_BIN = '1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_ACCUM, S_DRAIN, S_DUMP} state_e;

  state_e              state_q, state_d;
  logic                fv_q;
  logic [BIN_BITS-1:0] clr_addr_q, clr_addr_d;
  logic                drain_cnt_q, drain_cnt_d;
  logic                out_vld_q, out_vld_d;
  logic [BIN_BITS-1:0] out_bin_q, out_bin_d;
  logic                out_last_q, out_last_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic                a_vld_q;
  logic [BIN_BITS-1:0] a_bin_q;
  logic                w_vld_q;
  logic [BIN_BITS-1:0] w_bin_q;
  logic [CNT_W-1:0]    w_cnt_q;
  logic                x_vld_q;
  logic [BIN_BITS-1:0] x_bin_q;
  logic [CNT_W-1:0]    x_cnt_q;

  logic [CNT_W-1:0]    mem_q [NBINS];
  logic [CNT_W-1:0]    rd_q;

  logic                re, we;
  logic [BIN_BITS-1:0] ra, wa;
  logic [CNT_W-1:0]    wd;
  logic                fv_rise, pix_vld, xfer;
  logic [BIN_BITS-1:0] pix_bin, nxt_bin;
  logic [CNT_W-1:0]    old_cnt, inc_cnt;
  logic                pd_unused;

  assign fv_rise   = fv_i && !fv_q;
  assign pix_bin   = pd_i[PIX_W-1 -: BIN_BITS];
  assign pd_unused = ^pd_i;
  assign xfer      = out_vld_q && hist_ready_i;
  assign nxt_bin   = out_bin_q + 1'b1;
  assign pix_vld   = fv_i && lv_i &&
                     ((state_q == S_ACCUM) || ((state_q == S_IDLE) && fv_rise));

  // The RAM read of a bin can miss the two most recent increments still in flight.
  always_comb begin
    old_cnt = rd_q;
    if (w_vld_q && (w_bin_q == a_bin_q)) begin
      old_cnt = w_cnt_q;
    end else if (x_vld_q && (x_bin_q == a_bin_q)) begin
      old_cnt = x_cnt_q;
    end
  end

`ifdef HISTO_SATURATE_EN
  assign inc_cnt = (&old_cnt) ? old_cnt : old_cnt + CNT_W'(1);
`else
  assign inc_cnt = old_cnt + CNT_W'(1);
`endif

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    drain_cnt_d = drain_cnt_q;
    out_vld_d   = out_vld_q;
    out_bin_d   = out_bin_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    re          = 1'b0;
    ra          = pix_bin;
    we          = 1'b0;
    wa          = w_bin_q;
    wd          = w_cnt_q;
    case (state_q)
      S_CLEAR: begin
        we         = 1'b1;
        wa         = clr_addr_q;
        wd         = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        drop_d     = fv_rise;
        if (clr_addr_q == LAST_BIN) state_d = S_IDLE;
      end
      S_IDLE: begin
        re = pix_vld;
        we = w_vld_q;
        if (fv_rise) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        re = pix_vld;
        we = w_vld_q;
        if (!fv_i) begin
          state_d     = S_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      S_DRAIN: begin
        we          = w_vld_q;
        drop_d      = fv_rise;
        drain_cnt_d = 1'b1;
        // Last increment retires in the first drain cycle, so bin 0 is read in the second.
        if (drain_cnt_q) begin
          state_d    = S_DUMP;
          re         = 1'b1;
          ra         = '0;
          out_vld_d  = 1'b1;
          out_bin_d  = '0;
          out_last_d = (LAST_BIN == '0);
        end
      end
      S_DUMP: begin
        drop_d = fv_rise;
        if (xfer) begin
          we = 1'b1;
          wa = out_bin_q;
          wd = '0;
          if (out_last_q) begin
            state_d    = S_IDLE;
            out_vld_d  = 1'b0;
            out_bin_d  = '0;
            out_last_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            re         = 1'b1;
            ra         = nxt_bin;
            out_bin_d  = nxt_bin;
            out_last_d = (nxt_bin == LAST_BIN);
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk_pixel_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_CLEAR;
      fv_q        <= 1'b0;
      clr_addr_q  <= '0;
      drain_cnt_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      a_vld_q     <= 1'b0;
      a_bin_q     <= '0;
      w_vld_q     <= 1'b0;
      w_bin_q     <= '0;
      w_cnt_q     <= '0;
      x_vld_q     <= 1'b0;
      x_bin_q     <= '0;
      x_cnt_q     <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      fv_q        <= fv_i;
      clr_addr_q  <= clr_addr_d;
      drain_cnt_q <= drain_cnt_d;
      out_vld_q   <= out_vld_d;
      out_bin_q   <= out_bin_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      a_vld_q     <= pix_vld;
      a_bin_q     <= pix_bin;
      w_vld_q     <= a_vld_q;
      w_bin_q     <= a_bin_q;
      w_cnt_q     <= inc_cnt;
      x_vld_q     <= w_vld_q;
      x_bin_q     <= w_bin_q;
      x_cnt_q     <= w_cnt_q;
      if (re) rd_q <= mem_q[ra];
    end
  end

  always_ff @(posedge clk_pixel_i) begin
    if (we) mem_q[wa] <= wd;
  end

  assign hist_valid_o = out_vld_q;
  assign hist_bin_o   = out_bin_q;
  assign hist_count_o = out_vld_q ? rd_q : '0;
  assign hist_last_o  = out_last_q;
  assign frame_done_o = done_q;
  assign frame_drop_o = drop_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_histo_accum.sv
// Directed bench for histo_accum: a 24-bit instance plus a 4-bit instance sharing all inputs.
`timescale 1ns/1ps
module tb_histo_accum;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fv = 1'b0, lv = 1'b0, rdy = 1'b0;
  logic [9:0] pd = '0;

  logic        m_vld, m_last, m_done, m_drop, m_busy;
  logic [7:0]  m_bin;
  logic [23:0] m_cnt;
  logic        s_vld, s_last, s_done, s_drop, s_busy;
  logic [7:0]  s_bin;
  logic [3:0]  s_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_cnt[256];

  histo_accum u_dut (
    .clk_pixel_i(clk), .reset_n_i(rst_n), .fv_i(fv), .lv_i(lv), .pd_i(pd),
    .hist_ready_i(rdy), .hist_valid_o(m_vld), .hist_bin_o(m_bin),
    .hist_count_o(m_cnt), .hist_last_o(m_last), .frame_done_o(m_done),
    .frame_drop_o(m_drop), .busy_o(m_busy)
  );

  histo_accum #(.CNT_W(4)) u_small (
    .clk_pixel_i(clk), .reset_n_i(rst_n), .fv_i(fv), .lv_i(lv), .pd_i(pd),
    .hist_ready_i(rdy), .hist_valid_o(s_vld), .hist_bin_o(s_bin),
    .hist_count_o(s_cnt), .hist_last_o(s_last), .frame_done_o(s_done),
    .frame_drop_o(s_drop), .busy_o(s_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic int small_exp(input int c);
`ifdef HISTO_SATURATE_EN
    return (c > 15) ? 15 : c;
`else
    return c % 16;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l, input logic [9:0] p);
    fv = f; lv = l; pd = p;
    tick();
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 256; i++) exp_cnt[i] = 0;
  endtask

  task automatic pixel(input logic [9:0] p);
    exp_cnt[p[9:2]] = exp_cnt[p[9:2]] + 1;
    drive(1'b1, 1'b1, p);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_vld"}, m_vld, 0);
    chk({tag, "_bin"}, m_bin, 0);
    chk({tag, "_cnt"}, m_cnt, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_drop"}, m_drop, 0);
    chk({tag, "_busy"}, m_busy, 1);
  endtask

  // Lowers fv, then accepts the whole dump and checks every beat against exp_cnt.
  task automatic run_dump(input bit rnd, input bit drop_mid);
    int idx = 0, cyc = 0, first = -1, drops = 0;
    bit stall = 0;
    logic [7:0] pb = '0;
    logic [23:0] pc = '0;
    fv = 1'b0; lv = 1'b0;
    while (idx < 256 && cyc < 5000) begin
      if (m_vld && first < 0) first = cyc;
      if (stall) begin
        chk("hold_vld", m_vld, 1);
        chk("hold_bin", m_bin, pb);
        chk("hold_cnt", m_cnt, pc);
      end
      if (drop_mid && idx == 100 && !fv) begin
        fv = 1'b1; lv = 1'b1; pd = 10'h004;
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_vld && rdy) begin
        chk($sformatf("beat%0d_bin", idx), m_bin, idx);
        chk($sformatf("bin%0d_cnt", idx), m_cnt, exp_cnt[idx]);
        chk($sformatf("bin%0d_last", idx), m_last, (idx == 255));
        chk($sformatf("bin%0d_small_cnt", idx), s_cnt, small_exp(exp_cnt[idx]));
        idx++;
      end
      stall = m_vld && !rdy;
      pb = m_bin;
      pc = m_cnt;
      drops += int'(m_drop);
      tick();
      cyc++;
    end
    chk("dump_beats", idx, 256);
    chk("first_beat_by_t3", (first >= 0 && first <= 3), 1);
    chk("frame_done_hi", m_done, 1);
    chk("valid_after_dump", m_vld, 0);
    chk("busy_after_dump", m_busy, 0);
    drops += int'(m_drop);
    tick();
    chk("frame_done_one_cycle", m_done, 0);
    chk("drop_pulses", drops, drop_mid ? 1 : 0);
  endtask

  initial begin
    int busy_n, vld_n, drop_n, done_n;

    // Reset, then an idle CLEAR period
    tick(); tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    busy_n = 0; vld_n = 0;
    for (int i = 0; i < 300; i++) begin
      busy_n += int'(m_busy);
      vld_n += int'(m_vld);
      tick();
    end
    chk("clear_busy_cycles", busy_n, 256);
    chk("clear_no_valid", vld_n, 0);

    // 4 lines x 8 pixels at 10'h004
    clear_exp();
    exp_cnt[1] = 32;
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) drive(1'b1, 1'b1, 10'h004);
      drive(1'b1, 1'b0, '0);
    end
    run_dump(1'b0, 1'b0);

    // Ramp line with first pixel on the fv edge, then 50 pixels at 10'h3FF
    clear_exp();
    for (int b = 0; b < 255; b++) exp_cnt[b] = 4;
    exp_cnt[255] = 54;
    for (int i = 0; i < 1024; i++) drive(1'b1, 1'b1, 10'(i));
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 10'h3FF);
    run_dump(1'b0, 1'b0);

    // Two identical frames, dumped with random backpressure
    for (int f = 0; f < 2; f++) begin
      clear_exp();
      drive(1'b1, 1'b0, '0);
      for (int l = 0; l < 2; l++) begin
        for (int i = 0; i < 20; i++) pixel(10'(((i / 3) * 97 + l * 5) % 1024));
        drive(1'b1, 1'b0, '0);
      end
      run_dump(1'b1, 1'b0);
    end

    // Frame start during DUMP is dropped, even once IDLE is reached
    clear_exp();
    exp_cnt[1] = 32;
    drive(1'b1, 1'b0, '0);
    for (int l = 0; l < 4; l++) begin
      for (int p = 0; p < 8; p++) drive(1'b1, 1'b1, 10'h004);
      drive(1'b1, 1'b0, '0);
    end
    run_dump(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 10'h004);
    chk("dropped_frame_stays_idle", m_busy, 0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    clear_exp();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) pixel(10'h000);
    run_dump(1'b0, 1'b0);
    chk("after_drop_bin0", exp_cnt[0], 10);

    // Reset in the middle of a dump
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 10'h004);
    fv = 1'b0; lv = 1'b0; rdy = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_dump_valid", m_vld, 1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    tick();
    rst_n = 1'b1;

    // Frame starting during CLEAR is dropped; held fv through IDLE stays ignored
    busy_n = int'(m_busy);
    drop_n = 0; done_n = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, 10'h000);
      if (i == 0) chk("clear_drop_pulse", m_drop, 1);
      busy_n += int'(m_busy);
      drop_n += int'(m_drop);
      done_n += int'(m_done);
    end
    chk("reclear_busy_cycles", busy_n, 256);
    chk("reclear_drop_count", drop_n, 1);
    chk("reclear_no_done", done_n, 0);
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    chk("held_frame_ignored", m_busy, 0);

    // 20 pixels in bin 0: exact on the wide instance, saturated/wrapped on the 4-bit one
    clear_exp();
    drive(1'b1, 1'b0, '0);
    for (int i = 0; i < 20; i++) pixel(10'h000);
    run_dump(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
